// File: rtl/vga_scanout_reader_if.sv
// vga_scanout_reader_if: video memory read port plus VGA DAC/sync pins and blanking status.
interface vga_scanout_reader_if;
  logic [16:0] rd_addr;
  logic [2:0]  rd_data;
  logic [7:0]  vga_r;
  logic [7:0]  vga_g;
  logic [7:0]  vga_b;
  logic        vga_hs;
  logic        vga_vs;
  logic        vga_blank_n;
  logic        vga_sync_n;
  logic        vga_clk;
  logic        vblank;
  logic        frame_start;
  modport master (
    output rd_addr, vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n, vga_sync_n, vga_clk, vblank, frame_start,
    input  rd_data
  );
  modport slave (
    input  rd_addr, vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n, vga_sync_n, vga_clk, vblank, frame_start,
    output rd_data
  );
endinterface

// File: rtl/vga_scanout_reader.sv
// vga_scanout_reader: 640x480@60 VGA timing that scans a 2x2-doubled 320x240x3 framebuffer out to the DAC.
module vga_scanout_reader #(
  parameter int H_VIS  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_VIS  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33,
  parameter int FB_W   = 320
) (
  input logic clk,
  input logic reset,
  vga_scanout_reader_if.master bus
);
  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  logic       pix_ce;
  logic [9:0] h;
  logic [9:0] v;
  logic       h_last;
  logic       v_last;
  logic       vis;
  logic       hs_n;
  logic       vs_n;
  always_comb begin
    h_last = h == 10'(H_TOT - 1);
    v_last = v == 10'(V_TOT - 1);
    vis = h < 10'(H_VIS) && v < 10'(V_VIS);
    hs_n = !(h >= 10'(H_VIS + H_FP) && h <= 10'(H_VIS + H_FP + H_SYNC - 1));
    vs_n = !(v >= 10'(V_VIS + V_FP) && v <= 10'(V_VIS + V_FP + V_SYNC - 1));
    bus.rd_addr = 17'(v[9:1]) * 17'(FB_W) + 17'(h[9:1]);
  end
  assign bus.vga_sync_n = 1'b0;
  assign bus.vga_clk = pix_ce;
  // Address is held for both clks of a pixel, so the 1-clk RAM data is ready by the pix_ce edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      pix_ce <= 1'b0;
      h <= '0;
      v <= '0;
      bus.vga_r <= '0;
      bus.vga_g <= '0;
      bus.vga_b <= '0;
      bus.vga_hs <= 1'b1;
      bus.vga_vs <= 1'b1;
      bus.vga_blank_n <= 1'b0;
      bus.vblank <= 1'b0;
      bus.frame_start <= 1'b0;
    end else begin
      pix_ce <= !pix_ce;
      bus.frame_start <= pix_ce && h_last && v == 10'(V_VIS - 1);
      if (pix_ce) begin
        h <= h_last ? '0 : h + 10'd1;
        if (h_last) v <= v_last ? '0 : v + 10'd1;
        bus.vga_r <= vis ? {8{bus.rd_data[2]}} : 8'h00;
        bus.vga_g <= vis ? {8{bus.rd_data[1]}} : 8'h00;
        bus.vga_b <= vis ? {8{bus.rd_data[0]}} : 8'h00;
        bus.vga_hs <= hs_n;
        bus.vga_vs <= vs_n;
        bus.vga_blank_n <= vis;
        bus.vblank <= v >= 10'(V_VIS);
      end
    end
  end
endmodule

// File: tb/tb_vga_scanout_reader.sv
// tb_vga_scanout_reader: full-size and shrunken-geometry scanout checked against a closed-form pixel model.
module tb_vga_scanout_reader;
  typedef struct packed {
    logic [16:0] addr;
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
    logic        hs;
    logic        vs;
    logic        blank_n;
    logic        vblank;
    logic        frame_start;
    logic        vclk;
    logic        sync_n;
  } obs_t;
  logic clk = 0;
  logic ra = 1;
  logic rb = 1;
  logic force_a = 0;
  int ea = 0;
  int eb = 0;
  int tests = 0;
  int fails = 0;
  logic [2:0] mem [0:131071];
  obs_t ga, gb;
  vga_scanout_reader_if ia();
  vga_scanout_reader_if ib();
  vga_scanout_reader dut_a (.clk(clk), .reset(ra), .bus(ia));
  vga_scanout_reader #(
    .H_VIS(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_VIS(8), .V_FP(2), .V_SYNC(2), .V_BP(2), .FB_W(8)
  ) dut_b (.clk(clk), .reset(rb), .bus(ib));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    ea <= ra ? 0 : ea + 1;
    eb <= rb ? 0 : eb + 1;
    ia.rd_data <= force_a ? 3'b111 : mem[ia.rd_addr];
    ib.rd_data <= mem[ib.rd_addr];
  end
  assign ga = {ia.rd_addr, ia.vga_r, ia.vga_g, ia.vga_b, ia.vga_hs, ia.vga_vs, ia.vga_blank_n,
               ia.vblank, ia.frame_start, ia.vga_clk, ia.vga_sync_n};
  assign gb = {ib.rd_addr, ib.vga_r, ib.vga_g, ib.vga_b, ib.vga_hs, ib.vga_vs, ib.vga_blank_n,
               ib.vblank, ib.frame_start, ib.vga_clk, ib.vga_sync_n};
  // Expected pins after e clock edges since reset: pixel p=e/2 is at the counters, pixel e/2-1 at the pins.
  function automatic obs_t model(int e, int hv, int hf, int hsy, int hb, int vv, int vf, int vsy, int vb, int fbw);
    int ht, vt, p, q, hq, vq, aq;
    logic vis;
    logic [2:0] d;
    obs_t o;
    ht = hv + hf + hsy + hb;
    vt = vv + vf + vsy + vb;
    p = e / 2;
    o = '0;
    o.vclk = e[0];
    o.hs = 1'b1;
    o.vs = 1'b1;
    o.addr = 17'((((p / ht) % vt) / 2) * fbw + (p % ht) / 2);
    if (e >= 2) begin
      q = e / 2 - 1;
      hq = q % ht;
      vq = (q / ht) % vt;
      aq = (vq / 2) * fbw + hq / 2;
      d = mem[aq];
      vis = hq < hv && vq < vv;
      o.r = vis ? {8{d[2]}} : 8'h00;
      o.g = vis ? {8{d[1]}} : 8'h00;
      o.b = vis ? {8{d[0]}} : 8'h00;
      o.hs = !(hq >= hv + hf && hq < hv + hf + hsy);
      o.vs = !(vq >= vv + vf && vq < vv + vf + vsy);
      o.blank_n = vis;
      o.vblank = vq >= vv;
      o.frame_start = !e[0] && hq == ht - 1 && vq == vv - 1;
    end
    return o;
  endfunction
  function automatic obs_t model_a(int e);
    return model(e, 640, 16, 96, 48, 480, 10, 2, 33, 320);
  endfunction
  function automatic obs_t model_b(int e);
    return model(e, 16, 2, 4, 2, 8, 2, 2, 2, 8);
  endfunction
  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if (ga !== model_a(0)) begin fails++; $display("FAIL reset_a got=%h exp=%h", ga, model_a(0)); end
    tests++;
    if (gb !== model_b(0)) begin fails++; $display("FAIL reset_b got=%h exp=%h", gb, model_b(0)); end
    ra = 0;
    rb = 0;
    repeat (40) begin
      @(negedge clk);
      tests++;
      if (ga !== model_a(ea)) begin fails++; $display("FAIL start_a e=%0d got=%h exp=%h", ea, ga, model_a(ea)); end
      tests++;
      if (gb !== model_b(eb)) begin fails++; $display("FAIL start_b e=%0d got=%h exp=%h", eb, gb, model_b(eb)); end
    end
  endtask
  task automatic test_scan();
    int last_fall = -1;
    int nfalls = 0;
    logic prev = ia.vga_hs;
    repeat (5000) begin
      @(negedge clk);
      tests++;
      if (ga !== model_a(ea)) begin fails++; $display("FAIL scan_a e=%0d got=%h exp=%h", ea, ga, model_a(ea)); end
      if (prev && !ia.vga_hs) begin
        if (last_fall >= 0) begin
          tests++;
          if (ea - last_fall !== 1600) begin fails++; $display("FAIL hs_period got=%0d exp=1600", ea - last_fall); end
        end
        last_fall = ea;
        nfalls++;
      end
      if (!prev && ia.vga_hs && last_fall >= 0) begin
        tests++;
        if (ea - last_fall !== 192) begin fails++; $display("FAIL hs_width got=%0d exp=192", ea - last_fall); end
      end
      prev = ia.vga_hs;
    end
    tests++;
    if (nfalls < 3) begin fails++; $display("FAIL hs_count got=%0d exp>=3", nfalls); end
  endtask
  task automatic wait_ea(int target);
    int guard = 0;
    while (ea < target && guard < 20000) begin @(negedge clk); guard++; end
    if (ea < target) begin tests++; fails++; $display("FAIL wait_a got=%0d exp=%0d", ea, target); end
  endtask
  task automatic test_addr_colour();
    int guard = 0;
    mem[641] = 3'b101;
    wait_ea(8006);
    tests++;
    if (ia.rd_addr !== 17'd641) begin fails++; $display("FAIL addr_3_5 got=%0d exp=641", ia.rd_addr); end
    wait_ea(8008);
    tests++;
    if ({ia.vga_r, ia.vga_g, ia.vga_b, ia.vga_blank_n} !== 25'h1FE01FF) begin
      fails++;
      $display("FAIL colour_101 got=%h exp=1fe01ff", {ia.vga_r, ia.vga_g, ia.vga_b, ia.vga_blank_n});
    end
    while (eb % 672 != 366 && guard < 1000) begin @(negedge clk); guard++; end
    tests++;
    if (ib.rd_addr !== 17'd31) begin fails++; $display("FAIL addr_last_b got=%0d exp=31", ib.rd_addr); end
  endtask
  task automatic test_blank_ones();
    force_a = 1;
    wait_ea(9200);
    while (ea < 9277) begin
      tests++;
      if ({ia.vga_r, ia.vga_g, ia.vga_b, ia.vga_blank_n} !== 25'h1FFFFFF) begin
        fails++;
        $display("FAIL ones_vis e=%0d got=%h exp=1ffffff", ea, {ia.vga_r, ia.vga_g, ia.vga_b, ia.vga_blank_n});
      end
      @(negedge clk);
    end
    wait_ea(9290);
    while (ea < 9560) begin
      tests++;
      if ({ia.vga_r, ia.vga_g, ia.vga_b, ia.vga_blank_n} !== 25'h0) begin
        fails++;
        $display("FAIL ones_blank e=%0d got=%h exp=0", ea, {ia.vga_r, ia.vga_g, ia.vga_b, ia.vga_blank_n});
      end
      @(negedge clk);
    end
    force_a = 0;
  endtask
  task automatic test_frame();
    int t_fs = -1;
    int t_vb = -1;
    int t_vs = -1;
    int nfs = 0;
    logic pfs = ib.frame_start;
    logic pvb = ib.vblank;
    logic pvs = ib.vga_vs;
    repeat (2100) begin
      @(negedge clk);
      tests++;
      if (gb !== model_b(eb)) begin fails++; $display("FAIL frame_b e=%0d got=%h exp=%h", eb, gb, model_b(eb)); end
      if (!pfs && ib.frame_start) begin
        if (t_fs >= 0) begin
          tests++;
          if (eb - t_fs !== 672) begin fails++; $display("FAIL fs_period got=%0d exp=672", eb - t_fs); end
        end
        t_fs = eb;
        nfs++;
      end
      if (!pvb && ib.vblank) begin
        if (t_fs >= 0) begin
          tests++;
          if (eb - t_fs !== 2) begin fails++; $display("FAIL vb_rise got=%0d exp=2", eb - t_fs); end
        end
        t_vb = eb;
      end
      if (pvb && !ib.vblank && t_vb >= 0) begin
        tests++;
        if (eb - t_vb !== 288) begin fails++; $display("FAIL vb_len got=%0d exp=288", eb - t_vb); end
      end
      if (pvs && !ib.vga_vs) t_vs = eb;
      if (!pvs && ib.vga_vs && t_vs >= 0) begin
        tests++;
        if (eb - t_vs !== 96) begin fails++; $display("FAIL vs_len got=%0d exp=96", eb - t_vs); end
      end
      pfs = ib.frame_start;
      pvb = ib.vblank;
      pvs = ib.vga_vs;
    end
    tests++;
    if (nfs < 3) begin fails++; $display("FAIL fs_count got=%0d exp>=3", nfs); end
  endtask
  task automatic test_mid_reset();
    repeat (int'($urandom_range(5, 60))) @(negedge clk);
    ra = 1;
    rb = 1;
    repeat (3) begin
      @(negedge clk);
      tests++;
      if (ga !== model_a(0)) begin fails++; $display("FAIL mid_rst_a got=%h exp=%h", ga, model_a(0)); end
      tests++;
      if (gb !== model_b(0)) begin fails++; $display("FAIL mid_rst_b got=%h exp=%h", gb, model_b(0)); end
    end
    ra = 0;
    rb = 0;
    repeat (200) begin
      @(negedge clk);
      tests++;
      if (ga !== model_a(ea)) begin fails++; $display("FAIL resume_a e=%0d got=%h exp=%h", ea, ga, model_a(ea)); end
      tests++;
      if (gb !== model_b(eb)) begin fails++; $display("FAIL resume_b e=%0d got=%h exp=%h", eb, gb, model_b(eb)); end
    end
  endtask
  initial begin
    for (int i = 0; i < 131072; i++) mem[i] = 3'($urandom);
    test_reset();
    test_scan();
    test_addr_colour();
    test_blank_ones();
    test_frame();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
